// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite register slave.
// Response codes, channel FSM states and byte-lane helper.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_e;

  function automatic int clog2_bytes(input int dw);
    return (dw == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/axil_ready_gate.sv
// Per-channel ready stall: ready is held off until valid has
// waited STALL_CYCLES eligible cycles; cleared on handshake.
module axil_ready_gate #(
  parameter int STALL_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic ready_in,
  output logic ready_out
);

  localparam logic [3:0] LIMIT = 4'(STALL_CYCLES);

  logic [3:0] cnt_q;

  assign ready_out = ready_in && (cnt_q >= LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (valid && ready_out) begin
      cnt_q <= '0;
    end else if (valid && ready_in) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/axil_slave_regs.sv
// AXI4-Lite slave register bank with byte strobes and write pulses.
// Define AXIL_SLV_STALL_EN to inject ready stalls on AW, W and AR.
module axil_slave_regs
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    NUM_REGS     = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    STALL_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BW    = clog2_bytes(DATA_WIDTH);
  localparam int IW    = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] SPAN =
    (ADDR_WIDTH+1)'(NUM_REGS * BYTES);

  function automatic logic hit(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
  endfunction

  function automatic logic [IW-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[BW +: IW];
  endfunction

  wr_state_e wr_q, wr_d;
  rd_state_e rd_q, rd_d;

  logic                  aw_full_q, w_full_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [BYTES-1:0]      w_strb_q;
  resp_e                 bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [NUM_REGS-1:0]   pulse_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic aw_rdy, w_rdy, ar_rdy;
  logic aw_hs, w_hs, ar_hs, commit;

  assign aw_rdy = (wr_q == WR_IDLE) && !aw_full_q;
  assign w_rdy  = (wr_q == WR_IDLE) && !w_full_q;
  assign ar_rdy = (rd_q == RD_IDLE);

`ifdef AXIL_SLV_STALL_EN
  axil_ready_gate #(.STALL_CYCLES(STALL_CYCLES)) u_aw_gate (
    .clk(clk), .rst_n(rst_n), .valid(awvalid),
    .ready_in(aw_rdy), .ready_out(awready)
  );
  axil_ready_gate #(.STALL_CYCLES(STALL_CYCLES)) u_w_gate (
    .clk(clk), .rst_n(rst_n), .valid(wvalid),
    .ready_in(w_rdy), .ready_out(wready)
  );
  axil_ready_gate #(.STALL_CYCLES(STALL_CYCLES)) u_ar_gate (
    .clk(clk), .rst_n(rst_n), .valid(arvalid),
    .ready_in(ar_rdy), .ready_out(arready)
  );
`else
  logic unused_cfg;
  assign unused_cfg = STALL_CYCLES[0];
  assign awready    = aw_rdy;
  assign wready     = w_rdy;
  assign arready    = ar_rdy;
`endif

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign commit = (wr_q == WR_IDLE) && aw_full_q && w_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= WR_IDLE;
      rd_q <= RD_IDLE;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    unique case (wr_q)
      WR_IDLE: if (commit) wr_d = WR_RESP;
      WR_RESP: if (bready) wr_d = WR_IDLE;
    endcase
    unique case (rd_q)
      RD_IDLE: if (ar_hs)  rd_d = RD_DATA;
      RD_DATA: if (rready) rd_d = RD_IDLE;
    endcase
  end

  always_comb begin
    bvalid     = (wr_q == WR_RESP);
    rvalid     = (rd_q == RD_DATA);
    bresp      = bresp_q;
    rresp      = rresp_q;
    rdata      = rdata_q;
    wr_pulse_o = pulse_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_full_q <= 1'b1;
          aw_addr_q <= awaddr;
        end
        if (w_hs) begin
          w_full_q <= 1'b1;
          w_data_q <= wdata;
          w_strb_q <= wstrb;
        end
      end
    end
  end

  // Commit uses the held AW/W pair; strobed bytes only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bresp_q <= OKAY;
      pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      pulse_q <= '0;
      if (commit) begin
        bresp_q <= hit(aw_addr_q) ? OKAY : SLVERR;
        if (hit(aw_addr_q)) begin
          pulse_q[idx(aw_addr_q)] <= 1'b1;
          for (int b = 0; b < BYTES; b++) begin
            if (w_strb_q[b])
              regs_q[idx(aw_addr_q)][b*8 +: 8] <= w_data_q[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else if (ar_hs) begin
      rdata_q <= hit(araddr) ? regs_q[idx(araddr)] : '0;
      rresp_q <= hit(araddr) ? OKAY : SLVERR;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++)
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: tb/tb_axil_slave_regs.sv
// Randomised self-check of axil_slave_regs against a register-array model.
// Stall timing is checked only when AXIL_SLV_STALL_EN is defined.
module tb_axil_slave_regs;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NR   = 16;
  localparam logic [31:0] BASE = 32'h40;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [AW-1:0]  awaddr = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [DW-1:0]  wdata = '0;
  logic [3:0]     wstrb = '0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready = 1'b0;
  logic [AW-1:0]  araddr = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready = 1'b0;
  logic [NR*DW-1:0] regs_o;
  logic [NR-1:0]  wr_pulse_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m [NR];

  always #5 clk = ~clk;

  axil_slave_regs #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
    .BASE_ADDR(BASE), .STALL_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < NR * 4);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [NR*DW-1:0] m_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = m[i];
    return f;
  endfunction

  function automatic void m_write(input logic [31:0] a, d,
                                  input logic [3:0] s);
    logic [31:0] v;
    if (!m_hit(a)) return;
    v = m[m_idx(a)];
    for (int b = 0; b < 4; b++)
      if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
    m[m_idx(a)] = v;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NR; i++) m[i] = '0;
  endfunction

  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    @(negedge clk);
    awaddr = a;
    awvalid = 1'b1;
    while (!awready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("aw_hs", awready, 1);
    @(posedge clk);
    #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    while (!wready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("w_hs", wready, 1);
    @(posedge clk);
    #1 wvalid = 1'b0;
  endtask

  task automatic finish_b(input logic [31:0] a, input int hold);
    int n = 0;
    logic [1:0]    er;
    logic [NR-1:0] ep;
    er = m_hit(a) ? 2'b00 : 2'b10;
    ep = m_hit(a) ? (NR'(1) << m_idx(a)) : '0;
    do begin
      @(negedge clk);
      n++;
    end while (!bvalid && n < 64);
    chk("b_lat", n, 2);
    chk("bresp", bresp, er);
    chk("pulse", wr_pulse_o, ep);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("b_hold", {bvalid, bresp}, {1'b1, er});
      chk("aw_w_rdy", {awready, wready}, 2'b00);
      chk("pulse_off", wr_pulse_o, 0);
    end
    bready = 1'b1;
    @(posedge clk);
    #1 bready = 1'b0;
    @(negedge clk);
    chk("b_done", bvalid, 0);
    chk("pulse_off", wr_pulse_o, 0);
    chk("regs", regs_o, m_flat());
  endtask

  task automatic do_write(input logic [31:0] a, d, input logic [3:0] s,
                          input int mode, input int hold);
    case (mode)
      0: fork
           send_aw(a);
           send_w(d, s);
         join
      1: begin
           send_w(d, s);
           @(negedge clk);
           chk("w_slot", wready, 0);
           repeat (3) @(posedge clk);
           send_aw(a);
         end
      default: begin
           send_aw(a);
           @(negedge clk);
           chk("aw_slot", awready, 0);
           repeat (2) @(posedge clk);
           send_w(d, s);
         end
    endcase
    m_write(a, d, s);
    finish_b(a, hold);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    int n = 0;
    logic [31:0] ed;
    logic [1:0]  er;
    ed = m_hit(a) ? m[m_idx(a)] : '0;
    er = m_hit(a) ? 2'b00 : 2'b10;
    @(negedge clk);
    araddr = a;
    arvalid = 1'b1;
    while (!arready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("ar_hs", arready, 1);
    @(posedge clk);
    #1 arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid", rvalid, 1);
    chk("rdata", rdata, ed);
    chk("rresp", rresp, er);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("r_hold", {rvalid, rresp, rdata}, {1'b1, er, ed});
      chk("ar_rdy", arready, 0);
    end
    rready = 1'b1;
    @(posedge clk);
    #1 rready = 1'b0;
    @(negedge clk);
    chk("r_done", rvalid, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8)
      return BASE + 32'($urandom_range(0, NR-1) * 4)
                  + 32'($urandom_range(0, 3));
    else if (r == 8)
      return BASE + NR*4 + 32'($urandom_range(0, 255));
    else
      return 32'($urandom_range(0, int'(BASE) - 1));
  endfunction

  initial begin
    m_clear();
    repeat (3) @(negedge clk);
    chk("rst_regs", regs_o, 0);
    chk("rst_bv_rv", {bvalid, rvalid, bresp, rresp}, 0);
    chk("rst_pulse", wr_pulse_o, 0);
`ifndef AXIL_SLV_STALL_EN
    chk("rst_rdy", {awready, wready, arready}, 3'b111);
`endif
    rst_n = 1'b1;

`ifdef AXIL_SLV_STALL_EN
    @(negedge clk);
    awaddr = BASE + 32'h3C;
    awvalid = 1'b1;
    chk("stall_c0", awready, 0);
    @(negedge clk);
    chk("stall_c1", awready, 0);
    @(negedge clk);
    chk("stall_c2", awready, 1);
    @(posedge clk);
    #1 awvalid = 1'b0;
    send_w(32'hCAFEF00D, 4'hF);
    m_write(BASE + 32'h3C, 32'hCAFEF00D, 4'hF);
    finish_b(BASE + 32'h3C, 0);
`endif

    do_write(BASE + 4, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(BASE + 4, 0);
    do_write(BASE + 8, 32'h11223344, 4'hF, 1, 1);
    do_read(BASE + 8, 1);
    do_write(BASE + 12, 32'hFFFFFFFF, 4'hF, 2, 0);
    do_write(BASE + 12, 32'h00000000, 4'h5, 0, 0);
    chk("reg3_strb", regs_o[3*DW +: DW], 32'hFF00FF00);
    do_write(BASE + 12, 32'h12345678, 4'h0, 0, 0);
    do_write(BASE + NR*4, 32'hA5A5A5A5, 4'hF, 0, 0);
    do_read(BASE + NR*4, 0);
    do_read(BASE - 4, 0);
    fork
      do_write(BASE + 20, 32'h0BADF00D, 4'hF, 0, 5);
      do_read(BASE + 4, 5);
    join

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2), $urandom_range(0, 4));
      else
        do_read(rand_addr(), $urandom_range(0, 4));
    end

    fork
      send_aw(BASE + 28);
      send_w(32'h77777777, 4'hF);
    join
    begin
      int n = 0;
      while (!bvalid && n < 64) begin
        @(negedge clk);
        n++;
      end
      chk("pre_rst_bv", bvalid, 1);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_bv", bvalid, 0);
    chk("rst_regs2", regs_o, 0);
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
    do_read(BASE + 28, 0);
    do_read(BASE + 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=done");
    $fatal(1);
  end

endmodule
